// File: rtl/sip_pkg.sv
// Shared constants, state encoding and the rotate helper for the SipHash round sequencer.
// Build option: define SIP_128_OUT_EN for SipHash-128 output (adds the FINALIZE2 state).
package sip_pkg;

    localparam logic [63:0] SIP_IV0 = 64'h736f6d6570736575;
    localparam logic [63:0] SIP_IV1 = 64'h646f72616e646f6d;
    localparam logic [63:0] SIP_IV2 = 64'h6c7967656e657261;
    localparam logic [63:0] SIP_IV3 = 64'h7465646279746573;

    localparam logic [63:0] SIP_FIN_XOR64  = 64'h00000000000000ff;
    localparam logic [63:0] SIP_FIN_XOR128 = 64'h00000000000000ee;
    localparam logic [63:0] SIP_FIN2_XOR   = 64'h00000000000000dd;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_MSG,
        ST_COMPRESS,
        ST_FINAL_XOR,
        ST_FINALIZE,
        ST_DONE
`ifdef SIP_128_OUT_EN
        , ST_FINALIZE2
`endif
    } sip_seq_state_t;

    typedef struct packed {
        logic [63:0] v0;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [63:0] v3;
    } sip_state_t;

    // Rotate left by a constant amount in 1..63.
    function automatic logic [63:0] sip_rotl(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

endpackage

// File: rtl/sip_half_step.sv
// One SipHash half-round: phase 0 uses rotations 13/16, phase 1 uses 17/21.
// Purely combinational; the sequencer owns all state.
module sip_half_step
    import sip_pkg::*;
(
    input  logic       phase,
    input  sip_state_t v,
    output sip_state_t v_next
);

    logic [63:0] sum_a;
    logic [63:0] sum_b;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        v_next = v;
        sum_a  = '0;
        sum_b  = '0;
        if (!phase) begin
            sum_a     = v.v0 + v.v1;
            sum_b     = v.v2 + v.v3;
            v_next.v1 = sip_rotl(v.v1, 13) ^ sum_a;
            v_next.v3 = sip_rotl(v.v3, 16) ^ sum_b;
            v_next.v0 = sip_rotl(sum_a, 32);
            v_next.v2 = sum_b;
        end else begin
            sum_a     = v.v2 + v.v1;
            sum_b     = v.v0 + v.v3;
            v_next.v1 = sip_rotl(v.v1, 17) ^ sum_a;
            v_next.v3 = sip_rotl(v.v3, 21) ^ sum_b;
            v_next.v2 = sip_rotl(sum_a, 32);
            v_next.v0 = sum_b;
        end
    end

endmodule

// File: rtl/sip_round_sequencer.sv
// Iterative SipHash-c-d controller: one half-round per clock over registered v0..v3.
// Build option: define SIP_128_OUT_EN for SipHash-128 (second finalisation pass, 128-bit result).
module sip_round_sequencer
    import sip_pkg::*;
#(
    parameter int C_ROUNDS = 2,
    parameter int D_ROUNDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [63:0]  s_data,
    input  logic         s_last,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic [127:0] hash_out
);

    localparam logic [4:0] C_TC = 5'(2 * C_ROUNDS - 1);
    localparam logic [4:0] D_TC = 5'(2 * D_ROUNDS - 1);

`ifdef SIP_128_OUT_EN
    localparam logic [63:0] INIT_V1_XOR = SIP_FIN_XOR128;
    localparam logic [63:0] FIN_XOR     = SIP_FIN_XOR128;
`else
    localparam logic [63:0] INIT_V1_XOR = 64'h0;
    localparam logic [63:0] FIN_XOR     = SIP_FIN_XOR64;
`endif

    sip_seq_state_t state;
    sip_state_t     v;
    sip_state_t     v_step;
    logic [63:0]    m_reg;
    logic           last_reg;
    logic [4:0]     cnt;
    logic           phase;
    logic [63:0]    hash_lo;
    logic [63:0]    hash_hi;
    logic [63:0]    digest;

    sip_half_step u_half_step (
        .phase  (phase),
        .v      (v),
        .v_next (v_step)
    );

    // Digest of the state as it will be after the current (final) half-step.
    assign digest   = v_step.v0 ^ v_step.v1 ^ v_step.v2 ^ v_step.v3;
    assign hash_out = {hash_hi, hash_lo};

`ifndef SIP_128_OUT_EN
    assign hash_hi = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the block override earlier ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            v          <= '0;
            m_reg      <= '0;
            last_reg   <= 1'b0;
            cnt        <= '0;
            phase      <= 1'b0;
            busy       <= 1'b0;
            s_ready    <= 1'b0;
            hash_valid <= 1'b0;
            hash_lo    <= '0;
`ifdef SIP_128_OUT_EN
            hash_hi    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        v.v0    <= key[63:0]   ^ SIP_IV0;
                        v.v1    <= key[127:64] ^ SIP_IV1 ^ INIT_V1_XOR;
                        v.v2    <= key[63:0]   ^ SIP_IV2;
                        v.v3    <= key[127:64] ^ SIP_IV3;
                        busy    <= 1'b1;
                        s_ready <= 1'b1;
                        state   <= ST_WAIT_MSG;
                    end
                end

                ST_WAIT_MSG: begin
                    if (s_valid) begin
                        v.v3     <= v.v3 ^ s_data;
                        m_reg    <= s_data;
                        last_reg <= s_last;
                        cnt      <= '0;
                        phase    <= 1'b0;
                        s_ready  <= 1'b0;
                        state    <= ST_COMPRESS;
                    end
                end

                ST_COMPRESS: begin
                    v <= v_step;
                    if (cnt == C_TC) begin
                        v.v0    <= v_step.v0 ^ m_reg;
                        cnt     <= '0;
                        phase   <= 1'b0;
                        s_ready <= !last_reg;
                        state   <= last_reg ? ST_FINAL_XOR : ST_WAIT_MSG;
                    end else begin
                        cnt   <= cnt + 5'd1;
                        phase <= !phase;
                    end
                end

                ST_FINAL_XOR: begin
                    v.v2  <= v.v2 ^ FIN_XOR;
                    cnt   <= '0;
                    phase <= 1'b0;
                    state <= ST_FINALIZE;
                end

                ST_FINALIZE: begin
                    v <= v_step;
                    if (cnt == D_TC) begin
                        hash_lo <= digest;
                        cnt     <= '0;
                        phase   <= 1'b0;
`ifdef SIP_128_OUT_EN
                        v.v1    <= v_step.v1 ^ SIP_FIN2_XOR;
                        state   <= ST_FINALIZE2;
`else
                        hash_valid <= 1'b1;
                        state      <= ST_DONE;
`endif
                    end else begin
                        cnt   <= cnt + 5'd1;
                        phase <= !phase;
                    end
                end

`ifdef SIP_128_OUT_EN
                ST_FINALIZE2: begin
                    v <= v_step;
                    if (cnt == D_TC) begin
                        hash_hi    <= digest;
                        cnt        <= '0;
                        phase      <= 1'b0;
                        hash_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt   <= cnt + 5'd1;
                        phase <= !phase;
                    end
                end
`endif

                ST_DONE: begin
                    if (hash_ready) begin
                        hash_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    s_ready    <= 1'b0;
                    hash_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sip_round_sequencer.sv
// Directed scoreboard bench for sip_round_sequencer using reference SipHash vectors.
// Expected digests are queued when the final word is driven and compared when hash_valid rises.
module tb_sip_round_sequencer;

    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [63:0]  W0  = 64'h0706050403020100;
    localparam logic [63:0]  W1  = 64'h0800000000000000;
`ifdef SIP_128_OUT_EN
    localparam int           LAT     = 21;
    localparam logic [127:0] E_EMPTY = 128'h930255c71472f66de6a825ba047f81a3;
`else
    localparam int           LAT     = 13;
    localparam logic [127:0] E_EMPTY = 128'h0000000000000000726fdb47dd0e0e31;
    localparam logic [127:0] E_TWO   = 128'h000000000000000093f5f5799a932462;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         s_valid;
    logic         s_ready;
    logic [63:0]  s_data;
    logic         s_last;
    logic         hash_valid;
    logic         hash_ready;
    logic [127:0] hash_out;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q[$];

    sip_round_sequencer #(.C_ROUNDS(2), .D_ROUNDS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .hash_out   (hash_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start s_ready", 128'(s_ready), 128'd1);
        check("start busy", 128'(busy), 128'd1);
    endtask

    // Offer a word after an idle gap and hold it until the sequencer takes it.
    task automatic send_word(input logic [63:0] d, input logic l, input int gap);
        logic acc;
        int   n;
        repeat (gap) step();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n       = 0;
        acc     = 1'b0;
        while (!acc && n < 100) begin
            acc = s_ready;
            step();
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("word accepted", 128'(acc), 128'd1);
        check("s_ready after accept", 128'(s_ready), 128'd0);
    endtask

    task automatic wait_result(input string tag);
        int           n;
        logic [127:0] exp;
        n = 0;
        while (!hash_valid && n < 200) begin
            step();
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        check({tag, " latency"}, 128'(n), 128'(LAT));
        check({tag, " hash_valid"}, 128'(hash_valid), 128'd1);
        check({tag, " hash_out"}, hash_out, exp);
        check({tag, " s_ready in DONE"}, 128'(s_ready), 128'd0);
    endtask

    task automatic accept();
        hash_ready = 1'b1;
        step();
        hash_ready = 1'b0;
        check("accept hash_valid", 128'(hash_valid), 128'd0);
        check("accept busy", 128'(busy), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        key        = KEY;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        hash_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 128'(busy), 128'd0);
        check("reset s_ready", 128'(s_ready), 128'd0);
        check("reset hash_valid", 128'(hash_valid), 128'd0);
        check("reset hash_out", hash_out, 128'd0);
        rst = 1'b0;
        step();
        check("idle busy", 128'(busy), 128'd0);

        // Empty message (single zero word with length byte 0).
        do_start();
        exp_q.push_back(E_EMPTY);
        send_word(64'h0, 1'b1, 0);
        wait_result("empty");

        // Consumer stalls: result must stay put and start must be ignored.
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold hash_valid", 128'(hash_valid), 128'd1);
            check("hold hash_out", hash_out, E_EMPTY);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check("start in DONE valid", 128'(hash_valid), 128'd1);
        check("start in DONE s_ready", 128'(s_ready), 128'd0);
        check("start in DONE hash_out", hash_out, E_EMPTY);
        accept();

`ifndef SIP_128_OUT_EN
        // Eight-byte message, back-to-back words (second word held while busy).
        do_start();
        send_word(W0, 1'b0, 0);
        exp_q.push_back(E_TWO);
        send_word(W1, 1'b1, 0);
        wait_result("two word");
        accept();

        // Same message with random source gaps.
        for (int i = 0; i < 3; i++) begin
            do_start();
            send_word(W0, 1'b0, int'($urandom_range(0, 7)));
            exp_q.push_back(E_TWO);
            send_word(W1, 1'b1, int'($urandom_range(0, 7)));
            wait_result("gapped");
            accept();
        end

        // start coinciding with the DONE accept is dropped.
        do_start();
        exp_q.push_back(E_EMPTY);
        send_word(64'h0, 1'b1, 0);
        wait_result("empty again");
        hash_ready = 1'b1;
        start      = 1'b1;
        step();
        hash_ready = 1'b0;
        start      = 1'b0;
        check("start at accept busy", 128'(busy), 128'd0);
        step();
        check("start at accept still idle", 128'(busy), 128'd0);
        check("start at accept s_ready", 128'(s_ready), 128'd0);
`endif

        // Asynchronous reset in the middle of compression.
        do_start();
        send_word(W0, 1'b0, 0);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("abort busy", 128'(busy), 128'd0);
        check("abort s_ready", 128'(s_ready), 128'd0);
        check("abort hash_valid", 128'(hash_valid), 128'd0);
        check("abort hash_out", hash_out, 128'd0);
        step();
        rst = 1'b0;
        step();
        check("after abort busy", 128'(busy), 128'd0);

        do_start();
        exp_q.push_back(E_EMPTY);
        send_word(64'h0, 1'b1, 0);
        wait_result("post reset");
        accept();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
